// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 FFT block.
// Holds the frame-sequencer state encoding and the pipeline-latency helper.
package fft_pkg;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_UNLOAD  = 2'd2
  } fft_ctrl_state_t;

  // Total butterfly pipeline depth: one group of stage registers per radix-2 stage.
  function automatic int fft_ctrl_pipe_lat(input int points, input int stage_lat);
    return $clog2(points) * stage_lat;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up-counter with synchronous clear; wrap flags the increment that returns to 0.
module mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = en & (count == WIDTH'(MODULUS - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (clr)  count <= '0;
    else if (wrap) count <= '0;
    else if (en)   count <= count + 1'b1;
  end

endmodule

// File: rtl/fft_ctrl.sv
// Frame sequencer for the radix-2 FFT datapath: load N samples, wait out the
// butterfly pipeline, then stream N results with backpressure. Single-buffered.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int FFT_POINTS    = 8,
  parameter int STAGE_LATENCY = 1,
  parameter int FRAME_CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ctrl_valid_in,
  output logic                          ctrl_ready_in,
  input  logic                          ctrl_flush,
  output logic                          shift_en,
  output logic                          compute_start,
  input  logic                          ctrl_ready_out,
  output logic                          ctrl_valid_out,
  output logic                          ctrl_last_out,
  output logic [$clog2(FFT_POINTS)-1:0] out_idx,
  output logic                          frame_done,
  output logic [FRAME_CNT_W-1:0]        frame_cnt,
  output logic                          busy
);

  localparam int LOG2N    = $clog2(FFT_POINTS);
  localparam int PIPE_LAT = fft_ctrl_pipe_lat(FFT_POINTS, STAGE_LATENCY);
  localparam int IDX_W    = LOG2N;
  localparam int LAT_W    = $clog2(PIPE_LAT + 1);

  fft_ctrl_state_t state, state_nxt;

  logic             accept, out_hs, lat_en;
  logic [IDX_W-1:0] scnt;
  logic [LAT_W-1:0] lcnt;
  logic             smp_wrap, lat_wrap, lat_last, idx_wrap;

  assign accept   = ctrl_valid_in & ctrl_ready_in & ~ctrl_flush;
  assign out_hs   = ctrl_valid_out & ctrl_ready_out & ~ctrl_flush;
  assign lat_en   = (state == S_COMPUTE) & ~ctrl_flush;
  assign lat_last = lat_wrap & (lcnt == LAT_W'(PIPE_LAT - 1));
  assign shift_en = accept;
  assign busy     = (state != S_LOAD) | (scnt != '0);

  mod_counter #(.WIDTH(IDX_W), .MODULUS(FFT_POINTS)) u_smp_cnt (
    .clk(clk), .rst(rst), .clr(ctrl_flush), .en(accept), .count(scnt), .wrap(smp_wrap)
  );

  mod_counter #(.WIDTH(LAT_W), .MODULUS(PIPE_LAT)) u_lat_cnt (
    .clk(clk), .rst(rst), .clr(ctrl_flush), .en(lat_en), .count(lcnt), .wrap(lat_wrap)
  );

  mod_counter #(.WIDTH(IDX_W), .MODULUS(FFT_POINTS)) u_idx_cnt (
    .clk(clk), .rst(rst), .clr(ctrl_flush), .en(out_hs), .count(out_idx), .wrap(idx_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    ctrl_ready_in  = 1'b0;
    ctrl_valid_out = 1'b0;
    ctrl_last_out  = 1'b0;
    case (state)
      S_LOAD: begin
        ctrl_ready_in = ~rst;
        if (smp_wrap) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (lat_last) state_nxt = S_UNLOAD;
      end
      S_UNLOAD: begin
        ctrl_valid_out = 1'b1;
        ctrl_last_out  = (out_idx == IDX_W'(FFT_POINTS - 1));
        if (idx_wrap) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
    if (ctrl_flush) state_nxt = S_LOAD;
  end

  // Flush already masks accept and handshake, so these pulses cannot fire on an aborted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compute_start <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      compute_start <= smp_wrap;
      frame_done    <= idx_wrap;
      if (idx_wrap) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed self-checking bench for fft_ctrl with N=8, STAGE_LATENCY=1 (pipeline latency 3).
module tb_fft_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vin = 1'b0;
  logic        rout = 1'b0;
  logic        flush = 1'b0;
  logic        ready_in, shift_en, compute_start, valid_out, last_out, frame_done, busy;
  logic [2:0]  out_idx;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  fft_ctrl #(.FFT_POINTS(8), .STAGE_LATENCY(1), .FRAME_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ctrl_valid_in(vin), .ctrl_ready_in(ready_in), .ctrl_flush(flush),
    .shift_en(shift_en), .compute_start(compute_start),
    .ctrl_ready_out(rout), .ctrl_valid_out(valid_out), .ctrl_last_out(last_out),
    .out_idx(out_idx), .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int acc;
    int hs;
    int exp_idx;
    logic done;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // 1. Reset asserted mid-cycle
    #3 rst = 1'b1;
    #1;
    check("rst_ready_in", ready_in, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 check("rst_ready_in_held", ready_in, 0);
    @(negedge clk) rst = 1'b0;
    #1 check("post_rst_ready_in", ready_in, 1);

    // 2. Back-to-back frame
    vin = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("t2_shift_en", shift_en, 1);
      check("t2_cs_low", compute_start, 0);
      step();
    end
    check("t2_ready_in_low", ready_in, 0);
    check("t2_shift_en_low", shift_en, 0);
    check("t2_compute_start", compute_start, 1);
    vin = 1'b0;
    rout = 1'b1;
    #1;
    step();
    check("t2_cs_pulse_end", compute_start, 0);
    check("t2_valid_c1", valid_out, 0);
    step();
    check("t2_valid_c2", valid_out, 0);
    step();
    check("t2_valid_c3", valid_out, 1);
    for (int i = 0; i < 8; i++) begin
      check("t2_out_idx", out_idx, i);
      check("t2_valid", valid_out, 1);
      check("t2_last", last_out, (i == 7));
      check("t2_fd_low", frame_done, 0);
      step();
    end
    check("t2_frame_done", frame_done, 1);
    check("t2_frame_cnt", frame_cnt, 1);
    check("t2_valid_end", valid_out, 0);
    check("t2_ready_in_back", ready_in, 1);
    rout = 1'b0;
    #1;
    step();
    check("t2_fd_one_cycle", frame_done, 0);

    // 3. Input gaps 1,0,0,...
    acc = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      vin = (c % 3 == 0);
      #1;
      check("t3_shift_en", shift_en, vin);
      check("t3_cs_low", compute_start, 0);
      if (vin) acc++;
      step();
      if (acc == 8) done = 1'b1;
    end
    check("t3_done_in_bound", done, 1);
    check("t3_compute_start", compute_start, 1);
    check("t3_ready_in_low", ready_in, 0);
    vin = 1'b0;
    #1;
    repeat (3) step();
    check("t3_valid_after_lat", valid_out, 1);

    // 4. Output backpressure 1,0,0,1,0,1,...
    exp_idx = 0;
    hs = 0;
    for (int c = 0; c < 60 && hs < 8; c++) begin
      rout = pat[c % 6];
      #1;
      check("t4_out_idx", out_idx, exp_idx);
      check("t4_valid", valid_out, 1);
      check("t4_last", last_out, (exp_idx == 7));
      if (rout) begin
        exp_idx++;
        hs++;
      end
      step();
    end
    check("t4_handshakes", hs, 8);
    check("t4_frame_done", frame_done, 1);
    check("t4_frame_cnt", frame_cnt, 2);
    check("t4_valid_end", valid_out, 0);
    rout = 1'b0;

    // 5. Flush at out_idx=4 with ready_out high
    vin = 1'b1;
    #1;
    repeat (8) step();
    vin = 1'b0;
    #1;
    check("t5_compute_start", compute_start, 1);
    repeat (3) step();
    check("t5_valid", valid_out, 1);
    rout = 1'b1;
    #1;
    repeat (4) step();
    check("t5_idx_before", out_idx, 4);
    flush = 1'b1;
    #1;
    step();
    flush = 1'b0;
    rout = 1'b0;
    #1;
    check("t5_valid_low", valid_out, 0);
    check("t5_idx_clr", out_idx, 0);
    check("t5_no_frame_done", frame_done, 0);
    check("t5_frame_cnt", frame_cnt, 2);
    check("t5_ready_in", ready_in, 1);
    check("t5_busy", busy, 0);
    step();
    check("t5_no_frame_done_late", frame_done, 0);

    // 6. Async reset during S_COMPUTE
    vin = 1'b1;
    #1;
    repeat (8) step();
    vin = 1'b0;
    #1;
    check("t6_compute_start", compute_start, 1);
    step();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ready_in", ready_in, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cs", compute_start, 0);
    check("t6_rst_frame_cnt", frame_cnt, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("t6_no_cs", compute_start, 0);
      check("t6_no_valid", valid_out, 0);
      step();
    end
    vin = 1'b1;
    #1;
    repeat (8) step();
    vin = 1'b0;
    #1;
    check("t6_fresh_cs", compute_start, 1);
    repeat (3) step();
    rout = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("t6_out_idx", out_idx, i);
      step();
    end
    check("t6_frame_done", frame_done, 1);
    check("t6_frame_cnt", frame_cnt, 1);
    rout = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
